// File: rtl/div_unit_if.sv
// div_unit_if: E-stage divide request/response bundle between pipeline and divider.
interface div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             signed_div;
   logic             annul;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             div_running;
   logic             ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   modport master (output start, signed_div, annul, a, b, input div_running, ready, quotient, remainder);
   modport slave (input start, signed_div, annul, a, b, output div_running, ready, quotient, remainder);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
module div_unit #(parameter int WIDTH = 32) (
   input logic clk,
   input logic rst,
   div_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   stateT state;
   logic [CW-1:0] count;
   logic [WIDTH-1:0] prem, dvd, divisor, absA, absB, qRaw, nextPrem, quotReg, remReg;
   logic [WIDTH:0] shifted, diff;
   logic signQ, signR, qBit;
   always_comb begin
      absA = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      absB = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      shifted = {prem, dvd[WIDTH-1]};
      diff = shifted - {1'b0, divisor};
      // no borrow out of the (WIDTH+1)-bit subtract means shifted >= divisor
      qBit = ~diff[WIDTH];
      nextPrem = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      qRaw = {dvd[WIDTH-2:0], qBit};
   end
   // combinational so the E stage holds in the very cycle start first appears
   assign bus.div_running = ~bus.annul & ((state == IDLE & bus.start) | state == BUSY);
   assign bus.ready = (state == DONE) & ~bus.annul;
   assign bus.quotient = quotReg;
   assign bus.remainder = remReg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         prem <= '0;
         dvd <= '0;
         divisor <= '0;
         signQ <= 1'b0;
         signR <= 1'b0;
         quotReg <= '0;
         remReg <= '0;
      end else if (bus.annul) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               if (bus.b != '0) begin
                  dvd <= absA;
                  divisor <= absB;
                  prem <= '0;
                  count <= '0;
                  signQ <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  signR <= bus.signed_div & bus.a[WIDTH-1];
                  state <= BUSY;
               end else begin
                  quotReg <= '1;
                  remReg <= bus.a;
                  state <= DONE;
               end
            end
            BUSY: begin
               prem <= nextPrem;
               dvd <= qRaw;
               count <= count + 1'b1;
               if (count == LAST) begin
                  quotReg <= signQ ? -qRaw : qRaw;
                  remReg <= signR ? -nextPrem : nextPrem;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
